// File: rtl/pipe_add.sv
// Segmented carry-chain adder/subtractor, SEGS-deep pipeline, latency SEGS cycles.
// Backpressure: all stages hold while a result is stalled; in_ready = !out_valid || out_ready.
module pipe_add #(
  parameter int WIDTH  = 16,
  parameter int SEGS   = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW = WIDTH / SEGS;

  if (WIDTH < 2) begin : g_bad_width
    $error("pipe_add: WIDTH must be at least 2");
  end
  if (SEGS < 1) begin : g_bad_segs_min
    $error("pipe_add: SEGS must be at least 1");
  end
  if ((SEGS >= 1) && (WIDTH % SEGS != 0)) begin : g_bad_segs_div
    $error("pipe_add: WIDTH must be a multiple of SEGS");
  end

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    logic             src_vld;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_sub;
    logic [SW:0]      seg_dat;
    logic [WIDTH-1:0] s_nxt;

    logic             vld_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             sub_q;

    // Stage 0 folds subtraction into the operands: b is inverted and the carry forced to 1.
    if (k == 0) begin : g_head
      assign src_vld = in_valid;
      assign src_a   = a;
      assign src_b   = sub ? ~b : b;
      assign src_s   = '0;
      assign src_c   = sub | c_in;
      assign src_sub = sub;
    end else begin : g_body
      assign src_vld = g_stage[k-1].vld_q;
      assign src_a   = g_stage[k-1].a_q;
      assign src_b   = g_stage[k-1].b_q;
      assign src_s   = g_stage[k-1].s_q;
      assign src_c   = g_stage[k-1].c_q;
      assign src_sub = g_stage[k-1].sub_q;
    end

    assign seg_dat = {1'b0, src_a[k*SW +: SW]} + {1'b0, src_b[k*SW +: SW]} + {{SW{1'b0}}, src_c};

    always_comb begin
      s_nxt              = src_s;
      s_nxt[k*SW +: SW]  = seg_dat[SW-1:0];
    end

    // Payload only loads behind a valid bit, so bubbles never disturb held data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
        c_q   <= 1'b0;
        sub_q <= 1'b0;
      end else if (adv) begin
        vld_q <= src_vld;
        if (src_vld) begin
          a_q   <= src_a;
          b_q   <= src_b;
          s_q   <= s_nxt;
          c_q   <= seg_dat[SW];
          sub_q <= src_sub;
        end
      end
    end
  end

  assign out_valid = g_stage[SEGS-1].vld_q;
  assign sum       = g_stage[SEGS-1].s_q;
  assign c_out     = g_stage[SEGS-1].c_q;

  if (SIGNED) begin : g_ovf_signed
    assign ovf = (g_stage[SEGS-1].a_q[WIDTH-1] == g_stage[SEGS-1].b_q[WIDTH-1]) &&
                 (g_stage[SEGS-1].s_q[WIDTH-1] != g_stage[SEGS-1].a_q[WIDTH-1]);
  end else begin : g_ovf_unsigned
    assign ovf = g_stage[SEGS-1].c_q ^ g_stage[SEGS-1].sub_q;
  end

  // Last-stage operand copies are only partly consumed by the overflow logic.
  logic unused_last;
  assign unused_last = ^{g_stage[SEGS-1].a_q, g_stage[SEGS-1].b_q, g_stage[SEGS-1].sub_q};

endmodule

// File: tb/tb_pipe_add.sv
// Directed bench for pipe_add: 16-bit unsigned/signed/SEGS=1 instances plus a 4-bit exhaustive sweep.
module tb_pipe_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid, out_ready, c_in, sub;
  logic [15:0] a, b;

  logic        u_in_ready, u_out_valid, u_c_out, u_ovf;
  logic [15:0] u_sum;
  logic        s_in_ready, s_out_valid, s_c_out, s_ovf;
  logic [15:0] s_sum;
  logic        o_in_ready, o_out_valid, o_c_out, o_ovf;
  logic [15:0] o_sum;

  logic        v4, r4, cin4, sub4;
  logic [3:0]  a4, b4;
  logic        u4_in_ready, u4_out_valid, u4_c_out, u4_ovf;
  logic [3:0]  u4_sum;
  logic        s4_in_ready, s4_out_valid, s4_c_out, s4_ovf;
  logic [3:0]  s4_sum;

  int n_run  = 0;
  int n_fail = 0;

  pipe_add #(.WIDTH(16), .SEGS(4), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(u_out_valid), .out_ready(out_ready),
    .sum(u_sum), .c_out(u_c_out), .ovf(u_ovf));

  pipe_add #(.WIDTH(16), .SEGS(4), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(s_out_valid), .out_ready(out_ready),
    .sum(s_sum), .c_out(s_c_out), .ovf(s_ovf));

  pipe_add #(.WIDTH(16), .SEGS(1), .SIGNED(1'b0)) o_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(o_out_valid), .out_ready(out_ready),
    .sum(o_sum), .c_out(o_c_out), .ovf(o_ovf));

  pipe_add #(.WIDTH(4), .SEGS(2), .SIGNED(1'b0)) u4_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(u4_in_ready), .a(a4), .b(b4),
    .c_in(cin4), .sub(sub4), .out_valid(u4_out_valid), .out_ready(r4),
    .sum(u4_sum), .c_out(u4_c_out), .ovf(u4_ovf));

  pipe_add #(.WIDTH(4), .SEGS(2), .SIGNED(1'b1)) s4_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(s4_in_ready), .a(a4), .b(b4),
    .c_in(cin4), .sub(sub4), .out_valid(s4_out_valid), .out_ready(r4),
    .sum(s4_sum), .c_out(s4_c_out), .ovf(s4_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", n_run, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation on the 16-bit instances; checks SEGS=1 at one cycle and SEGS=4 latency/result.
  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eou, input logic eos);
    int lat;
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    check_eq({tag, "_s1_vld"}, 32'(o_out_valid), 32'd1);
    check_eq({tag, "_s1_sum"}, 32'(o_sum), 32'(es));
    while (!u_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq({tag, "_sum"}, 32'(u_sum), 32'(es));
    check_eq({tag, "_cout"}, 32'(u_c_out), 32'(ec));
    check_eq({tag, "_ovf_u"}, 32'(u_ovf), 32'(eou));
    check_eq({tag, "_ovf_s"}, 32'(s_ovf), 32'(eos));
    @(posedge clk); #1;
  endtask

  initial begin
    int k, first, last, di, stall, n_seen, idx, nres;
    logic first_seen, acc, take;
    logic [15:0] held, tsum;
    logic [15:0] exp6 [6];
    logic [10:0] exp_q [$];
    logic [10:0] got4, e4;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    v4 = 1'b0; r4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(u_in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(u_out_valid), 32'd0);
    check_eq("rst_sum", 32'(u_sum), 32'd0);
    check_eq("rst_cout_ovf", {30'd0, u_c_out, u_ovf}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("add_basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_one("add_wrap",  16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0);
    run_one("add_sovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    run_one("sub_sovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    run_one("sub_cin_ign", 16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream, out_ready held high.
    out_ready = 1'b1; c_in = 1'b0; sub = 1'b0;
    k = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; a = 16'(cyc); b = 16'(cyc * 3);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (u_out_valid) begin
        check_eq("b2b_sum", 32'(u_sum), 32'(4 * k));
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
    end
    check_eq("b2b_count", 32'(k), 32'd8);
    check_eq("b2b_first", 32'(first), 32'd3);
    check_eq("b2b_span", 32'(last - first + 1), 32'd8);

    // Stream of 6 with a 3-cycle output stall when the first result shows up.
    for (int i = 0; i < 6; i++) exp6[i] = 16'(i * 257 + i + 7);
    di = 0; k = 0; stall = 0; first_seen = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
      if (u_out_valid && !first_seen) begin
        first_seen = 1'b1; stall = 3; held = u_sum;
      end
      out_ready = (stall == 0);
      in_valid = (di < 6);
      a = 16'(di * 257); b = 16'(di + 7);
      #1;
      if (stall > 0) begin
        check_eq("stall_in_ready", 32'(u_in_ready), 32'd0);
        check_eq("stall_out_valid", 32'(u_out_valid), 32'd1);
        check_eq("stall_sum_hold", 32'(u_sum), 32'(held));
      end
      acc  = in_valid && u_in_ready;
      take = u_out_valid && out_ready;
      tsum = u_sum;
      @(posedge clk); #1;
      if (acc) di++;
      if (take) begin
        check_eq("stall_order", 32'(tsum), 32'(exp6[k]));
        k++;
      end
      if (stall > 0) stall--;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("stall_count", 32'(k), 32'd6);
    check_eq("stall_accepts", 32'(di), 32'd6);
    @(posedge clk); #1;

    // Reset with three operations in flight, the oldest already presented at the output.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'(i + 1); b = 16'h0100; c_in = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_pre_vld", 32'(u_out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_vld", 32'(u_out_valid), 32'd0);
    check_eq("rst_mid_sum", 32'(u_sum), 32'd0);
    check_eq("rst_mid_rdy", 32'(u_in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (u_out_valid) n_seen++;
    end
    check_eq("rst_no_stale", 32'(n_seen), 32'd0);
    run_one("post_rst", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep of a, b, c_in, sub with bubbles and random backpressure.
    idx = 0; nres = 0;
    for (int cyc = 0; cyc < 4000 && (idx < 1024 || exp_q.size() != 0); cyc++) begin
      v4   = (idx < 1024) && (cyc % 5 != 4);
      a4   = 4'(idx);
      b4   = 4'(idx >> 4);
      cin4 = 1'((idx >> 8) & 1);
      sub4 = 1'((idx >> 9) & 1);
      r4   = ($urandom_range(0, 3) != 0);
      #1;
      acc  = v4 && u4_in_ready;
      take = u4_out_valid && r4;
      got4 = {s4_sum, u4_c_out, u4_ovf, s4_ovf, u4_sum};
      if (acc) begin
        int ia, ib, r, sa, sb, sr;
        logic ec, eou, eos;
        ia = idx & 15; ib = (idx >> 4) & 15;
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        if (sub4) begin
          r = ia - ib; ec = (ia >= ib); eou = (ia < ib); sr = sa - sb;
        end else begin
          r = ia + ib + int'(cin4); ec = (r > 15); eou = (r > 15); sr = sa + sb + int'(cin4);
        end
        eos = (sr > 7) || (sr < -8);
        exp_q.push_back({4'(r), ec, eou, eos, 4'(r)});
        idx++;
      end
      if (take) begin
        if (exp_q.size() == 0) begin
          check_eq("sweep_extra", 32'(got4), 32'd0 - 32'd1);
        end else begin
          e4 = exp_q.pop_front();
          check_eq("sweep_res", 32'(got4), 32'(e4));
          nres++;
        end
      end
      @(posedge clk); #1;
    end
    v4 = 1'b0;
    check_eq("sweep_count", 32'(nres), 32'd1024);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_add.md
PIPE_ADD -- requirements
Module: pipe_add

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (>=2).
REQ-002 Parameter SEGS, default 4, carry-chain segments and pipeline depth (>=1); WIDTH%SEGS!=0 SHALL cause an elaboration error.
REQ-003 Parameter SIGNED, default 0, 1 = two's-complement overflow rule for ovf, 0 = unsigned rule.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  a, b, c_in and sub hold a valid operation.
REQ-007 in_ready  output  1  block accepts the operation this cycle.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 c_in  input  1  carry-in; used only when sub=0.
REQ-011 sub  input  1  0 = a+b+c_in, 1 = a-b computed as a+~b+1.
REQ-012 out_valid  output  1  sum, c_out and ovf hold a completed result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-015 c_out  output  1  carry out of bit WIDTH-1; for sub=1, 1 = no borrow.
REQ-016 ovf  output  1  overflow flag, see REQ-022.

Function
REQ-017 Pipeline of SEGS stages; stage k SHALL add bits [(k+1)*W/SEGS-1 : k*W/SEGS] with the carry registered from stage k-1, carrying unprocessed operand bits and completed sum bits forward in registers.
REQ-018 Latency SHALL be exactly SEGS cycles from accept (in_valid&&in_ready at edge) to out_valid, absent stalls.
REQ-019 Throughput SHALL be one operation per cycle when out_ready is held 1.
REQ-020 adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally; all stages SHALL shift only when adv=1, otherwise hold every register including valid bits.
REQ-021 A stage whose valid bit is 0 is a bubble; bubbles SHALL shift like data; no bubble collapsing.
REQ-022 ovf: SIGNED=1 -> (a[W-1]==b_eff[W-1]) && (sum[W-1]!=a[W-1]) with b_eff=sub?~b:b; SIGNED=0 -> c_out^sub.
REQ-023 Result transferred when out_valid&&out_ready at an edge; simultaneous transfer and new accept SHALL both occur in that cycle.
REQ-024 sum, c_out, ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 in_valid=0 cycles SHALL insert bubbles; input values SHALL be ignored when in_valid=0.
REQ-026 SEGS=1 SHALL behave as a single registered full-width adder, latency 1.
REQ-027 Results SHALL exit in acceptance order; none dropped or duplicated.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all stage valid bits, out_valid=0, sum=0, c_out=0, ovf=0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; first accept after release produces out_valid SEGS cycles later.
REQ-030 in_ready SHALL read 1 during and after reset (pipeline empty).

Verification
REQ-031 Defaults, out_ready=1: a=16'h00FF, b=16'h0001, c_in=0, sub=0 -> 4 cycles later sum=16'h0100, c_out=0, ovf=0.
REQ-032 Defaults: a=16'hFFFF, b=16'h0001, c_in=1 -> sum=16'h0001, c_out=1, ovf=1; SIGNED=1 same stimulus -> ovf=0.
REQ-033 SIGNED=1: a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1; a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, ovf=1, c_out=1.
REQ-034 Back-to-back 8 ops a=i, b=i*3, i=0..7, out_ready=1 -> 8 consecutive out_valid cycles, sum=4i in order.
REQ-035 Stream 6 ops, drop out_ready 3 cycles when first result appears -> in_ready=0 for those cycles, first sum held stable, all 6 results in order, no loss.
REQ-036 Assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately, no stale results after release; exhaustive WIDTH=4,SEGS=2 sweep of a,b,c_in,sub matches reference arithmetic.
